// File: rtl/branch_predictor.sv
// Direct-mapped branch target predictor with 2-bit saturating counters.
// Combinational lookup from the fetch PC; resolved branches update the table through a two-stage pipeline.
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        flush_table
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic [ENTRIES-1:0] r_valid;
    logic [TAGW-1:0]    r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic               r_u1_valid;
    logic [31:2]        r_u1_pc;
    logic               r_u1_taken;
    logic [31:0]        r_u1_target;

    logic [IDX-1:0]     w_f_idx;
    logic [TAGW-1:0]    w_f_tag;
    logic               w_f_hit;
    logic [IDX-1:0]     w_u_idx;
    logic [TAGW-1:0]    w_u_tag;
    logic               w_u_hit;
    logic               w_u_we;
    logic [1:0]         w_u_ctr;
    logic [31:0]        w_u_target;
    logic [ENTRIES-1:0] w_entry_we;
    logic               w_unused;

    // Byte-offset bits carry no information for word-aligned branches.
    assign w_unused = ^{fetch_pc[1:0], update_pc[1:0]};

    assign w_f_idx        = fetch_pc[IDX+1:2];
    assign w_f_tag        = fetch_pc[31:IDX+2];
    assign w_f_hit        = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign predict_taken  = w_f_hit && r_ctr[w_f_idx][1];
    assign predict_target = predict_taken ? r_target[w_f_idx] : fetch_pc + 32'd4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_u1_valid  <= 1'b0;
            r_u1_pc     <= '0;
            r_u1_taken  <= 1'b0;
            r_u1_target <= '0;
        end else if (flush_table) begin
            r_u1_valid  <= 1'b0;
        end else begin
            r_u1_valid <= update_en;
            if (update_en) begin
                r_u1_pc     <= update_pc[31:2];
                r_u1_taken  <= update_taken;
                r_u1_target <= update_target;
            end
        end
    end

    // U2 reads the entry as already modified by the previous update, so back-to-back hits chain correctly.
    assign w_u_idx = r_u1_pc[IDX+1:2];
    assign w_u_tag = r_u1_pc[31:IDX+2];
    assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_we  = r_u1_valid && (w_u_hit || r_u1_taken);

    always_comb begin
        w_u_ctr    = r_ctr[w_u_idx];
        w_u_target = r_target[w_u_idx];
        if (!w_u_hit) begin
            w_u_ctr    = 2'b10;
            w_u_target = r_u1_target;
        end else if (r_u1_taken) begin
            w_u_ctr    = (r_ctr[w_u_idx] == 2'b11) ? 2'b11 : r_ctr[w_u_idx] + 2'd1;
            w_u_target = r_u1_target;
        end else begin
            w_u_ctr    = (r_ctr[w_u_idx] == 2'b00) ? 2'b00 : r_ctr[w_u_idx] - 2'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_we
            assign w_entry_we[gi] = w_u_we && (w_u_idx == IDX'(gi));
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (flush_table) begin
                    r_valid[i] <= 1'b0;
                end else if (w_entry_we[i]) begin
                    r_valid[i]  <= 1'b1;
                    r_tag[i]    <= w_u_tag;
                    r_target[i] <= w_u_target;
                    r_ctr[i]    <= w_u_ctr;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table model
// whose updates are held in a queue and land one edge after being accepted.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX     = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] fetch_pc = 32'h100;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        update_en = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        flush_table = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    branch_predictor #(.ENTRIES(ENTRIES)) dut (
        .CLK(CLK), .RST(RST), .fetch_pc(fetch_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .flush_table(flush_table)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } upd_t;

    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    upd_t        m_pend [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_pend.delete();
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i;
        i  = int'((pc >> 2) % ENTRIES);
        t  = m_valid[i] && (m_tag[i] == (pc >> (IDX + 2))) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_apply(input upd_t u);
        int i;
        bit hit;
        i   = int'((u.pc >> 2) % ENTRIES);
        hit = m_valid[i] && (m_tag[i] == (u.pc >> (IDX + 2)));
        if (hit && u.taken) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_tgt[i] = u.tgt;
        end else if (hit) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (u.taken) begin
            m_valid[i] = 1; m_tag[i] = u.pc >> (IDX + 2); m_tgt[i] = u.tgt; m_ctr[i] = 2;
        end
    endtask

    task automatic model_edge();
        upd_t u;
        if (flush_table) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            m_pend.delete();
        end else begin
            while (m_pend.size() > 0) model_apply(m_pend.pop_front());
            if (update_en) begin
                u.pc = update_pc; u.taken = update_taken; u.tgt = update_target;
                m_pend.push_back(u);
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, check lookup, then advance the model on the rising edge.
    task automatic step(input logic ue, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utg, input logic fl, input logic [31:0] fpc);
        logic        et;
        logic [31:0] etg;
        @(negedge CLK);
        update_en = ue; update_pc = upc; update_taken = ut; update_target = utg;
        flush_table = fl; fetch_pc = fpc;
        #1;
        model_predict(fpc, et, etg);
        check("step_taken", {31'd0, predict_taken}, {31'd0, et});
        check("step_target", predict_target, etg);
        $display("txn %0d: upd=%0b pc=%h t=%0b tgt=%h flush=%0b fetch=%h -> %0b %h",
                 n_txn, ue, upc, ut, utg, fl, fpc, predict_taken, predict_target);
        n_txn++;
        @(posedge CLK);
        model_edge();
    endtask

    task automatic idle(input logic [31:0] fpc);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, fpc);
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tg);
        fetch_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
        check({tag, "_target"}, predict_target, exp_tg);
    endtask

    function automatic logic [31:0] rand_pc();
        return ({30'($urandom_range(0, 3)), 2'b00} << (IDX + 2 - 2))
             | (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        model_reset();
        #1;
        look("reset", 32'h100, 1'b0, 32'h104);
        #11 RST = 1'b0;
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Allocation latency: visible two cycles after the request, not one.
        step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100);
        look("lat_n1", 32'h100, 1'b0, 32'h104);
        idle(32'h100);
        look("lat_n2", 32'h100, 1'b1, 32'h200);

        // Counter walks down and saturates at strong not-taken.
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h100);
        idle(32'h100);
        look("dec1", 32'h100, 1'b0, 32'h104);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h100);
        step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h100);
        step(1'b1, 32'h100, 1'b1, 32'h280, 1'b0, 32'h100);
        idle(32'h100);
        look("sat_lo", 32'h100, 1'b0, 32'h104);
        step(1'b1, 32'h100, 1'b1, 32'h2C0, 1'b0, 32'h100);
        idle(32'h100);
        look("inc", 32'h100, 1'b1, 32'h2C0);

        // Alias at the same index replaces the entry with a weak-taken counter.
        step(1'b1, 32'h100, 1'b1, 32'h300, 1'b0, 32'h100);
        step(1'b1, 32'h140, 1'b1, 32'h400, 1'b0, 32'h140);
        idle(32'h140);
        look("alias_old", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h400);
        step(1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 32'h140);
        idle(32'h140);
        look("alias_weak", 32'h140, 1'b0, 32'h144);

        // Flush on the edge where U2 writes, with a new request alongside.
        step(1'b1, 32'h180, 1'b1, 32'h500, 1'b0, 32'h180);
        step(1'b1, 32'h1C0, 1'b1, 32'h600, 1'b1, 32'h180);
        idle(32'h180);
        idle(32'h1C0);
        look("flush_pend", 32'h180, 1'b0, 32'h184);
        look("flush_new", 32'h1C0, 1'b0, 32'h1C4);

        // Asynchronous reset while an update sits in U1.
        step(1'b1, 32'h200, 1'b1, 32'h700, 1'b0, 32'h200);
        idle(32'h200);
        look("pre_rst", 32'h200, 1'b1, 32'h700);
        step(1'b1, 32'h240, 1'b1, 32'h800, 1'b0, 32'h200);
        #1 RST = 1'b1;
        look("async_rst", 32'h200, 1'b0, 32'h204);
        model_reset();
        #1 RST = 1'b0;
        idle(32'h240);
        idle(32'h240);
        look("rst_lost", 32'h240, 1'b0, 32'h244);

        // Randomized traffic over a small PC pool to force hits, aliases and chains.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) != 0), rand_pc(), $urandom_range(0, 1) == 1,
                 $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 63) == 0) ? 32'hFFFF_FFFC : rand_pc());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, meaning the number of direct-mapped table entries; it SHALL be a power of two and at least 2; IDX = log2(ENTRIES).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have port fetch_pc, input, 32 bits: the fetch-stage PC being looked up.
REQ-005 The block SHALL have port predict_taken, output, 1 bit: the prediction that fetch_pc is a taken branch.
REQ-006 The block SHALL have port predict_target, output, 32 bits: the next fetch PC.
REQ-007 The block SHALL have port update_en, input, 1 bit: a resolved conditional branch is present this cycle.
REQ-008 The block SHALL have port update_pc, input, 32 bits: the PC of the resolved branch.
REQ-009 The block SHALL have port update_taken, input, 1 bit: the resolved outcome, driven by branch resolution branch_taken.
REQ-010 The block SHALL have port update_target, input, 32 bits: the resolved target, driven by branch resolution branch_addr.
REQ-011 The block SHALL have port flush_table, input, 1 bit: invalidate all entries.

Function
REQ-012 Each entry SHALL hold valid (1 bit), tag (32-IDX-2 bits), target (32 bits) and ctr (2 bits); ctr encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-013 The index SHALL be pc[IDX+1:2] and the tag SHALL be pc[31:IDX+2]; pc[1:0] SHALL be ignored.
REQ-014 Lookup SHALL be combinational from fetch_pc: hit = valid and tag match at the index.
REQ-015 predict_taken SHALL be hit and ctr[1].
REQ-016 predict_target SHALL be the entry target when predict_taken=1; otherwise it SHALL be fetch_pc+4, computed modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-017 Updates SHALL be pipelined in two stages: stage U1 registers {update_en, update_pc, update_taken, update_target} on the edge where update_en=1; stage U2 writes the table on the following edge.
REQ-018 An update SHALL be visible to lookup starting 2 cycles after the cycle in which update_en was asserted; there is no bypass from U1 to lookup.
REQ-019 U1 SHALL accept a new update every cycle (back-to-back), and updates SHALL be applied in order.
REQ-020 On an update hit with taken=1, the block SHALL saturating-increment ctr (11 stays 11) and overwrite target.
REQ-021 On an update hit with taken=0, the block SHALL saturating-decrement ctr (00 stays 00) and leave target unchanged.
REQ-022 On an update miss with taken=1, the block SHALL allocate the entry, replacing any existing entry: valid=1, tag set, target=update_target, ctr=10.
REQ-023 On an update miss with taken=0, the table SHALL be unchanged (no allocation).
REQ-024 Two consecutive updates to the same index SHALL both apply, the second operating on the result of the first.
REQ-025 When flush_table=1, all valid bits SHALL be cleared on that edge and the U1 register SHALL be emptied; an update applied by U2 on the same edge SHALL be discarded (flush wins); update_en in the same cycle SHALL be dropped.
REQ-026 Lookup SHALL remain combinational while flush_table is asserted: it reflects pre-flush contents until the edge.

Reset
REQ-027 While RST=1, the block SHALL, asynchronously, clear all valid bits, set every ctr=01, every target=0 and every tag=0, and empty the U1 register.
REQ-028 During and after reset, predict_taken SHALL be 0 and predict_target SHALL be fetch_pc+4.
REQ-029 An update in U1 when RST asserts SHALL be lost.
REQ-030 The first update SHALL be accepted on the first rising edge with RST=0.

Verification
REQ-031 Reset then fetch_pc=0x00000100 -> predict_taken=0, predict_target=0x00000104.
REQ-032 Update pc=0x00000100, taken=1, target=0x00000200 at cycle N -> lookup 0x00000100 gives predict_taken=1 and target 0x00000200 from cycle N+2, and not at N+1.
REQ-033 After REQ-032, two not-taken updates to 0x00000100 -> ctr 10->01->00; predict_taken=0 after the first has landed; a further not-taken update keeps ctr=00.
REQ-034 Alias test, ENTRIES=16: allocate 0x00000100 taken, then update 0x00000140 taken (same index, different tag) -> lookup 0x00000100 misses; lookup 0x00000140 hits with ctr=10.
REQ-035 Flush asserted in the same cycle that U2 writes, with update_en=1 -> afterwards all lookups miss, including both the pending and the new update.
REQ-036 Assert RST asynchronously mid-update with a value in U1 -> predict_taken=0 immediately; that update is never applied.
